// File: rtl/bus_read_unpacker_pkg.sv
// Shared FSM encoding and sizing helper for the bus read unpacker.
package bus_read_unpacker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } unpack_state_t;

   // Ceiling log2; C_LOG_2(1) = 0.
   function automatic int C_LOG_2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bus_read_pack_reg.sv
// Word assembly register plus valid/ready output stage for the bus read unpacker.
// BUS_RD_UNPACK_ZEROPAD_EN: assembly slots are zeroed on every packet transfer.
module bus_read_pack_reg #(
   parameter int DATA_LEN  = 16,
   parameter int NUM_WORDS = 4,
   parameter int IDX_W     = 2
)(
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          clr,
   input  logic                          wr_en,
   input  logic [IDX_W-1:0]              wr_idx,
   input  logic [DATA_LEN-1:0]           wr_data,
   input  logic                          xfer_req,
   input  logic                          xfer_last,
   output logic                          xfer_ok,
   output logic [NUM_WORDS*DATA_LEN-1:0] out_data,
   output logic                          out_valid,
   output logic                          out_last,
   input  logic                          out_ready
);

   logic [DATA_LEN-1:0] asm_q [NUM_WORDS];
   logic [DATA_LEN-1:0] out_q [NUM_WORDS];
   logic                xfer;

   assign xfer_ok = ~out_valid | out_ready;
   assign xfer    = xfer_req & xfer_ok;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         asm_q <= '{default: '0};
      end else begin
`ifdef BUS_RD_UNPACK_ZEROPAD_EN
         if (clr || xfer) asm_q <= '{default: '0};
`endif
         if (wr_en && !clr) asm_q[wr_idx] <= wr_data;
      end
   end

   // Output register only reloads when empty or being accepted, so data is stable under stall.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_q     <= '{default: '0};
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (clr) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (xfer) begin
         out_q     <= asm_q;
         out_valid <= 1'b1;
         out_last  <= xfer_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

   for (genvar k = 0; k < NUM_WORDS; k++) begin : g_out
      assign out_data[k*DATA_LEN +: DATA_LEN] = out_q[k];
   end

endmodule

// File: rtl/bus_read_unpacker.sv
// Pops words from the bus read FIFO and packs NUM_WORDS of them per output beat.
// BUS_RD_UNPACK_ZEROPAD_EN: unfilled slots of a partial final packet read as zero.
//
// state | meaning
// IDLE  | waiting for start; counters cleared
// RUN   | popping and assembling words, full packets handed to output stage
// FLUSH | all words landed, partial packet pending / last packet awaiting accept
// DONE  | one-cycle done pulse, back to IDLE
module bus_read_unpacker
   import bus_read_unpacker_pkg::*;
#(
   parameter int DATA_LEN  = 16,
   parameter int NUM_WORDS = 4,
   parameter int LEN_W     = 16,
   parameter int CNT_W     = C_LOG_2(NUM_WORDS) + 1
)(
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          start,
   input  logic [LEN_W-1:0]              len_words,
   input  logic                          abort,
   output logic                          busy,
   output logic                          done,
   output logic                          fifo_rd_en,
   input  logic [DATA_LEN-1:0]           fifo_rd_data,
   input  logic                          fifo_empty_w,
   output logic [NUM_WORDS*DATA_LEN-1:0] out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_last
);

   localparam int               IDX_W     = C_LOG_2(NUM_WORDS);
   localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(NUM_WORDS);
   localparam logic [CNT_W:0]   OCC_FULL  = (CNT_W+1)'(NUM_WORDS);

   unpack_state_t    state, state_nxt;
   logic [LEN_W-1:0] len_q, popped, landed;
   logic [CNT_W-1:0] fill;
   logic [CNT_W:0]   occ;
   logic             inflight;
   logic             all_landed, xfer_req, xfer_ok, xfer_last, last_accept;

   // Slots already filled plus the word still on its way from the FIFO.
   assign occ         = {1'b0, fill} + {{CNT_W{1'b0}}, inflight};
   assign all_landed  = (landed == len_q);
   assign fifo_rd_en  = (state == ST_RUN) & ~abort & ~fifo_empty_w &
                        (popped < len_q) & (occ < OCC_FULL);
   assign xfer_req    = ~abort & (((state == ST_RUN) & (fill == FILL_FULL)) |
                                  ((state == ST_FLUSH) & (fill != '0)));
   assign xfer_last   = (state == ST_FLUSH) | all_landed;
   assign last_accept = out_valid & out_ready & out_last;
   assign busy        = (state != ST_IDLE);
   assign done        = (state == ST_DONE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = (len_words == '0) ? ST_DONE : ST_RUN;
         ST_RUN: begin
            if (last_accept)                           state_nxt = ST_DONE;
            else if (all_landed && fill != FILL_FULL)  state_nxt = ST_FLUSH;
         end
         ST_FLUSH: if (last_accept) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (abort) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         len_q    <= '0;
         popped   <= '0;
         landed   <= '0;
         fill     <= '0;
         inflight <= 1'b0;
      end else if (abort) begin
         popped   <= '0;
         landed   <= '0;
         fill     <= '0;
         inflight <= 1'b0;
      end else if (state == ST_IDLE) begin
         popped   <= '0;
         landed   <= '0;
         fill     <= '0;
         inflight <= 1'b0;
         if (start) len_q <= len_words;
      end else begin
         inflight <= fifo_rd_en;
         if (fifo_rd_en) popped <= popped + LEN_W'(1);
         if (inflight)   landed <= landed + LEN_W'(1);
         if (xfer_req && xfer_ok) fill <= '0;
         else if (inflight)       fill <= fill + CNT_W'(1);
      end
   end

   bus_read_pack_reg #(
      .DATA_LEN  (DATA_LEN),
      .NUM_WORDS (NUM_WORDS),
      .IDX_W     (IDX_W)
   ) u_pack_reg (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (abort),
      .wr_en     (inflight & ~abort),
      .wr_idx    (fill[IDX_W-1:0]),
      .wr_data   (fifo_rd_data),
      .xfer_req  (xfer_req),
      .xfer_last (xfer_last),
      .xfer_ok   (xfer_ok),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

endmodule

// File: tb/tb_bus_read_unpacker.sv
// Scoreboard bench for bus_read_unpacker: FIFO model, random ready, packet reference model.
module tb_bus_read_unpacker;

   localparam int DL = 16;
   localparam int NW = 4;
   localparam int LW = 16;
   localparam int PW = DL * NW;
`ifdef BUS_RD_UNPACK_ZEROPAD_EN
   localparam bit ZP = 1'b1;
`else
   localparam bit ZP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [LW-1:0] len_words = '0;
   logic          busy, done, fifo_rd_en, out_valid, out_last;
   logic [DL-1:0] fifo_rd_data = '0;
   logic          fifo_empty_w = 1'b1;
   logic [PW-1:0] out_data;
   logic          out_ready = 1'b1;

   always #5 clk = ~clk;

   bus_read_unpacker #(.DATA_LEN(DL), .NUM_WORDS(NW), .LEN_W(LW)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .start        (start),
      .len_words    (len_words),
      .abort        (abort),
      .busy         (busy),
      .done         (done),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .fifo_empty_w (fifo_empty_w),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last)
   );

   typedef struct {
      logic [PW-1:0] data;
      bit            last;
   } pkt_t;

   pkt_t          exp_q[$];
   logic [DL-1:0] fifo_q[$];
   logic [DL-1:0] pending[$];
   logic [DL-1:0] stale[NW];
   int            checks = 0, errors = 0;
   int            pops_total = 0, done_count = 0, cyc = 0;
   int            pops0 = 0, dcount0 = 0;
   int            feed_period = 1, ready_pct = 100;
   bit            fifo_clr = 1'b0, done_due = 1'b0, hold_v = 1'b0;
   logic [PW-1:0] hold_d = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // FIFO with registered read data and registered empty flag; words trickle in from pending.
   always @(posedge clk) begin
      logic [DL-1:0] w;
      cyc++;
      if (fifo_clr) begin
         fifo_q.delete();
      end else begin
         if (fifo_rd_en && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            fifo_rd_data <= w;
            pops_total++;
         end
         if (pending.size() > 0 && (cyc % feed_period) == 0)
            fifo_q.push_back(pending.pop_front());
      end
      fifo_empty_w <= (fifo_q.size() == 0);
   end

   always @(posedge clk) begin
      #1;
      out_ready = (ready_pct >= 100) || (int'($urandom_range(0, 99)) < ready_pct);
   end

   // Monitor: scoreboard pops on handshake, plus done/stall/pop-while-empty rules.
   always @(negedge clk) begin
      bit   due;
      pkt_t p;
      if (rstn) begin
         due      = done_due;
         done_due = 1'b0;
         if (done) done_count++;
         if (done || due) chk("done pulse", 64'(done), 64'(due));
         if (!abort && !busy && start && len_words == '0) done_due = 1'b1;
         if (fifo_rd_en) chk("pop while empty", 64'(fifo_empty_w), 64'(0));
         if (hold_v) begin
            chk("stall valid held", 64'(out_valid), 64'(1));
            chk("stall data held", out_data, hold_d);
         end
         hold_v = out_valid && !out_ready && !abort;
         hold_d = out_data;
         if (out_valid && out_ready && !abort) begin
            chk("packet expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
               p = exp_q.pop_front();
               chk("packet data", out_data, p.data);
               chk("packet last", 64'(out_last), 64'(p.last));
               if (p.last) done_due = 1'b1;
            end
         end
      end
   end

   // Reference model: words grouped N per packet; missing slots are zero or keep the last word written there.
   task automatic add_expected(input logic [DL-1:0] w[$], input int L);
      int   np;
      pkt_t p;
      np = (L + NW - 1) / NW;
      for (int i = 0; i < np; i++) begin
         p.data = '0;
         for (int k = 0; k < NW; k++) begin
            int            idx;
            logic [DL-1:0] v;
            idx = i * NW + k;
            if (idx < L) begin
               v        = w[idx];
               stale[k] = v;
            end else begin
               v = ZP ? '0 : stale[k];
            end
            p.data[k*DL +: DL] = v;
         end
         p.last = (i == np - 1);
         exp_q.push_back(p);
      end
   endtask

   task automatic wait_pending();
      int n;
      n = 0;
      while (pending.size() > 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      chk("prefill drained", 64'(pending.size()), 64'(0));
   endtask

   task automatic begin_xfer(input int L, input bit seq, input int period, input bit prefill);
      logic [DL-1:0] w[$];
      for (int i = 0; i < L; i++) w.push_back(seq ? DL'(i + 1) : DL'($urandom));
      add_expected(w, L);
      feed_period = period;
      foreach (w[i]) pending.push_back(w[i]);
      if (prefill) wait_pending();
      pops0   = pops_total;
      dcount0 = done_count;
      @(posedge clk); #1;
      start = 1'b1;
      len_words = LW'(L);
      @(posedge clk); #1;
      start = 1'b0;
      if (L > 0) begin
         // A second command while busy must be ignored.
         @(posedge clk); #1;
         start = 1'b1;
         len_words = LW'(L + 3);
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   task automatic finish_xfer(input int L, input string tag);
      int n;
      n = 0;
      while (done_count == dcount0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " done seen"}, 64'(done_count != dcount0), 64'(1));
      chk({tag, " pop count"}, 64'(pops_total - pops0), 64'(L));
      chk({tag, " scoreboard drained"}, 64'(exp_q.size()), 64'(0));
      @(negedge clk);
      chk({tag, " idle after done"}, 64'(busy), 64'(0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, L;
      for (int k = 0; k < NW; k++) stale[k] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy", 64'(busy), 64'(0));
      chk("reset done", 64'(done), 64'(0));
      chk("reset fifo_rd_en", 64'(fifo_rd_en), 64'(0));
      chk("reset out_valid", 64'(out_valid), 64'(0));
      chk("reset out_last", 64'(out_last), 64'(0));
      chk("reset out_data", out_data, 64'(0));
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (2) @(posedge clk);

      // Two full packets from 1..8
      ready_pct = 100;
      begin_xfer(8, 1'b1, 1, 1'b1);
      finish_xfer(8, "len8");

      // Partial final packet
      begin_xfer(6, 1'b1, 1, 1'b1);
      finish_xfer(6, "len6");

      // Output stall after first packet: assembly fills, then pops stop
      ready_pct = 0;
      begin_xfer(12, 1'b0, 1, 1'b1);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      chk("stall pops", 64'(pops_total - pops0), 64'(2 * NW));
      chk("stall fifo_rd_en", 64'(fifo_rd_en), 64'(0));
      ready_pct = 100;
      finish_xfer(12, "stall");

      // FIFO runs empty between words
      begin_xfer(4, 1'b0, 6, 1'b0);
      finish_xfer(4, "trickle");

      // Abort the cycle after the first pop
      for (int i = 0; i < 8; i++) pending.push_back(DL'($urandom));
      feed_period = 1;
      wait_pending();
      dcount0 = done_count;
      @(posedge clk); #1;
      start = 1'b1;
      len_words = LW'(4);
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!fifo_rd_en && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("abort saw pop", 64'(fifo_rd_en), 64'(1));
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort busy", 64'(busy), 64'(0));
      chk("abort out_valid", 64'(out_valid), 64'(0));
      @(posedge clk); #1;
      fifo_clr = 1'b1;
      @(posedge clk); #1;
      fifo_clr = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort no done", 64'(done_count), 64'(dcount0));
      begin_xfer(4, 1'b0, 1, 1'b1);
      finish_xfer(4, "post-abort");

      // Zero-length command
      begin_xfer(0, 1'b0, 1, 1'b1);
      @(negedge clk);
      chk("len0 busy", 64'(busy), 64'(1));
      chk("len0 out_valid", 64'(out_valid), 64'(0));
      finish_xfer(0, "len0");

      // Randomized transfers with random feed rate and backpressure
      for (int r = 0; r < 8; r++) begin
         L = int'($urandom_range(1, 20));
         ready_pct = int'($urandom_range(40, 100));
         begin_xfer(L, 1'b0, int'($urandom_range(1, 3)), 1'b0);
         finish_xfer(L, "random");
      end
      ready_pct = 100;
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
